// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: program memory, PC and IR, with an FSM that
// fetches 32-bit words and resolves jumps, halt and no-ops locally. ALU
// instructions go to the execute unit over an ir_valid/ex_done handshake.
// The execute unit returns condition flags, which are latched here for later jumps.
module instr_fetch_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              ex_done,
  input  logic              flag_sign,
  input  logic              flag_zero,
  input  logic              flag_overflow,
  input  logic              flag_carry,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [4:0] OP_LAST_ALU = 5'b01011;
  localparam logic [4:0] OP_JMP      = 5'b01100;
  localparam logic [4:0] OP_JC       = 5'b01101;
  localparam logic [4:0] OP_JNC      = 5'b01110;
  localparam logic [4:0] OP_JS       = 5'b01111;
  localparam logic [4:0] OP_JNS      = 5'b10000;
  localparam logic [4:0] OP_JZ       = 5'b10001;
  localparam logic [4:0] OP_JNZ      = 5'b10010;
  localparam logic [4:0] OP_JV       = 5'b10011;
  localparam logic [4:0] OP_JNV      = 5'b10100;
  localparam logic [4:0] OP_HALT     = 5'b10101;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t            state_r;
  logic [31:0]       mem_r [DEPTH];
  logic              flag_s_r;
  logic              flag_z_r;
  logic              flag_v_r;
  logic              flag_c_r;

  logic [4:0]        opcode_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic              is_alu_s;
  logic              is_jump_s;
  logic              taken_s;
  logic              mem_we_s;

  // Evaluate a jump opcode against the latched flags; non-jumps never take.
  function automatic logic jump_taken(
    input logic [4:0] op,
    input logic       s,
    input logic       z,
    input logic       v,
    input logic       c
  );
    logic t;
    case (op)
      OP_JMP:  t = 1'b1;
      OP_JC:   t = c;
      OP_JNC:  t = ~c;
      OP_JS:   t = s;
      OP_JNS:  t = ~s;
      OP_JZ:   t = z;
      OP_JNZ:  t = ~z;
      OP_JV:   t = v;
      OP_JNV:  t = ~v;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign opcode_s  = ir[31:27];
  assign target_s  = ir[ADDR_W-1:0];
  assign pc_inc_s  = pc + PC_ONE;
  assign is_alu_s  = (opcode_s <= OP_LAST_ALU);
  assign is_jump_s = (opcode_s >= OP_JMP) && (opcode_s <= OP_JNV);
  assign taken_s   = jump_taken(opcode_s, flag_s_r, flag_z_r, flag_v_r, flag_c_r);
  // Loading is only allowed while the sequencer is parked.
  assign mem_we_s  = prog_we && ((state_r == ST_IDLE) || (state_r == ST_HALT));

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[prog_addr] <= prog_data;
    end
  end

  // Sequencer FSM with registered pc/ir/handshake/status outputs and latched flags.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r  <= ST_IDLE;
      pc       <= '0;
      ir       <= 32'h0000_0000;
      ir_valid <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      flag_s_r <= 1'b0;
      flag_z_r <= 1'b0;
      flag_v_r <= 1'b0;
      flag_c_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state_r  <= ST_FETCH;
            pc       <= '0;
            busy     <= 1'b1;
            halted   <= 1'b0;
            flag_s_r <= 1'b0;
            flag_z_r <= 1'b0;
            flag_v_r <= 1'b0;
            flag_c_r <= 1'b0;
          end
        end
        ST_FETCH: begin
          ir      <= mem_r[pc];
          state_r <= ST_DECODE;
        end
        ST_DECODE: begin
          if (is_alu_s) begin
            ir_valid <= 1'b1;
            state_r  <= ST_EXEC;
          end else if (is_jump_s) begin
            pc      <= taken_s ? target_s : pc_inc_s;
            state_r <= ST_FETCH;
          end else if (opcode_s == OP_HALT) begin
            busy    <= 1'b0;
            halted  <= 1'b1;
            state_r <= ST_HALT;
          end else begin
            // Undefined opcodes behave as no-ops.
            pc      <= pc_inc_s;
            state_r <= ST_FETCH;
          end
        end
        ST_EXEC: begin
          if (ex_done) begin
            flag_s_r <= flag_sign;
            flag_z_r <= flag_zero;
            flag_v_r <= flag_overflow;
            flag_c_r <= flag_carry;
            ir_valid <= 1'b0;
            pc       <= pc_inc_s;
            state_r  <= ST_FETCH;
          end
        end
        default: begin
          // Unreachable encodings fall back to a clean parked state.
          state_r  <= ST_IDLE;
          ir_valid <= 1'b0;
          busy     <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: hand sequences, a jump/NOP
// vector table, and randomized programs checked against an instruction-level
// model with random handshake latency and random ignored-input noise.
module tb_instr_fetch_sequencer;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic [31:0]   ir;
  logic          ir_valid;
  logic          ex_done;
  logic          flag_sign;
  logic          flag_zero;
  logic          flag_overflow;
  logic          flag_carry;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;

  instr_fetch_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .ir(ir), .ir_valid(ir_valid),
    .ex_done(ex_done), .flag_sign(flag_sign), .flag_zero(flag_zero),
    .flag_overflow(flag_overflow), .flag_carry(flag_carry), .pc(pc),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          noise_en = 1'b0;
  logic [31:0] m_mem [DEPTH];
  int          m_pc;
  logic [3:0]  m_flags;   // {S, Z, V, C}

  localparam logic [31:0] HALT_W = {5'b10101, 27'd0};

  typedef struct {
    logic [4:0] op;
    logic [3:0] flags;
    logic [3:0] exp_pc;
  } vec_t;
  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Jump rule from the opcode list: 12 always, then pairs (cond, not cond)
  // over carry, sign, zero, overflow.
  function automatic bit m_taken(input int op, input logic [3:0] f);
    int j;
    bit sel [4];
    bit neg;
    j = op - 12;
    if (j == 0) return 1'b1;
    sel = '{f[0], f[3], f[2], f[1]};
    neg = ((j - 1) % 2) == 1;
    return sel[(j - 1) / 2] ^ neg;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_noise();
    start = 1'b0; prog_we = 1'b0; ex_done = 1'b0;
  endtask

  // Inputs that the DUT must ignore while busy.
  task automatic set_noise(input bit allow_ex);
    clear_noise();
    if (noise_en) begin
      start     = ($urandom_range(0, 3) == 0);
      prog_we   = ($urandom_range(0, 2) == 0);
      prog_addr = AW'($urandom);
      prog_data = $urandom;
      ex_done   = allow_ex && ($urandom_range(0, 2) == 0);
      {flag_sign, flag_zero, flag_overflow, flag_carry} = 4'($urandom);
    end
  endtask

  task automatic load(input int a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    tick();
    prog_we = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_pc = 0; m_flags = 4'b0000;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_pc", 32'(pc), 32'd0);
  endtask

  task automatic async_reset();
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_ir_valid", 32'(ir_valid), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_ir", ir, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    tick();
    sys_rst = 1'b0;
    m_pc = 0; m_flags = 4'b0000;
  endtask

  // Executes one instruction from the FETCH cycle, checking against the model.
  task automatic step_instr(input int dly, input logic [3:0] fset, input bit fixed,
                            output bit hit_halt);
    logic [31:0] ins;
    int          op;
    int          k;
    logic [3:0]  f;
    ins = m_mem[m_pc];
    op  = int'(ins[31:27]);
    hit_halt = 1'b0;
    set_noise(1'b1);
    tick();
    chk("fetch_busy", 32'(busy), 32'd1);
    chk("fetch_pc", 32'(pc), 32'(m_pc));
    chk("fetch_ir_valid", 32'(ir_valid), 32'd0);
    set_noise(1'b1);
    tick();
    clear_noise();
    chk("decode_ir", ir, ins);
    if (op < 12) begin
      chk("alu_ir_valid", 32'(ir_valid), 32'd1);
      chk("alu_pc", 32'(pc), 32'(m_pc));
      k = (dly < 0) ? $urandom_range(0, 3) : dly;
      for (int i = 0; i < k; i++) begin
        set_noise(1'b0);
        tick();
        chk("exec_hold_valid", 32'(ir_valid), 32'd1);
        chk("exec_hold_pc", 32'(pc), 32'(m_pc));
      end
      f = fixed ? fset : 4'($urandom);
      set_noise(1'b0);
      ex_done = 1'b1;
      {flag_sign, flag_zero, flag_overflow, flag_carry} = f;
      tick();
      clear_noise();
      m_flags = f;
      m_pc = (m_pc + 1) % DEPTH;
      chk("exec_done_valid", 32'(ir_valid), 32'd0);
      chk("exec_done_pc", 32'(pc), 32'(m_pc));
    end else if (op <= 20) begin
      m_pc = m_taken(op, m_flags) ? int'(ins[3:0]) : (m_pc + 1) % DEPTH;
      chk("jump_pc", 32'(pc), 32'(m_pc));
      chk("jump_ir_valid", 32'(ir_valid), 32'd0);
      chk("jump_busy", 32'(busy), 32'd1);
    end else if (op == 21) begin
      hit_halt = 1'b1;
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_pc", 32'(pc), 32'(m_pc));
    end else begin
      m_pc = (m_pc + 1) % DEPTH;
      chk("nop_pc", 32'(pc), 32'(m_pc));
      chk("nop_ir_valid", 32'(ir_valid), 32'd0);
    end
  endtask

  task automatic run_prog(input int max_steps, output bit h);
    h = 1'b0;
    for (int i = 0; i < max_steps && !h; i++) begin
      step_instr(-1, 4'b0000, 1'b0, h);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    int r;
    logic [4:0] op;
    r = $urandom_range(0, 99);
    if (r < 40)      op = 5'($urandom_range(0, 11));
    else if (r < 75) op = 5'($urandom_range(12, 20));
    else if (r < 85) op = 5'd21;
    else             op = 5'($urandom_range(22, 31));
    return {op, 27'($urandom)};
  endfunction

  initial begin
    #10000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit h;
    tbl[0]  = '{5'b01100, 4'b0000, 4'd9};
    tbl[1]  = '{5'b01101, 4'b0001, 4'd9};
    tbl[2]  = '{5'b01101, 4'b1110, 4'd2};
    tbl[3]  = '{5'b01110, 4'b0001, 4'd2};
    tbl[4]  = '{5'b01110, 4'b1110, 4'd9};
    tbl[5]  = '{5'b01111, 4'b1000, 4'd9};
    tbl[6]  = '{5'b01111, 4'b0111, 4'd2};
    tbl[7]  = '{5'b10000, 4'b1000, 4'd2};
    tbl[8]  = '{5'b10000, 4'b0000, 4'd9};
    tbl[9]  = '{5'b10001, 4'b0100, 4'd9};
    tbl[10] = '{5'b10001, 4'b1011, 4'd2};
    tbl[11] = '{5'b10010, 4'b0100, 4'd2};
    tbl[12] = '{5'b10010, 4'b0000, 4'd9};
    tbl[13] = '{5'b10011, 4'b0010, 4'd9};
    tbl[14] = '{5'b10011, 4'b1101, 4'd2};
    tbl[15] = '{5'b10100, 4'b0010, 4'd2};
    tbl[16] = '{5'b10100, 4'b0000, 4'd9};
    tbl[17] = '{5'b10110, 4'b1111, 4'd2};
    tbl[18] = '{5'b11111, 4'b0101, 4'd2};

    sys_rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = 32'd0;
    ex_done = 1'b0; {flag_sign, flag_zero, flag_overflow, flag_carry} = 4'b0000;
    m_pc = 0; m_flags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    sys_rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) load(a, HALT_W);

    // mov then halt; ex_done two cycles after ir_valid rises.
    load(0, {5'b00001, 27'd5});
    do_start();
    step_instr(1, 4'b0000, 1'b1, h);
    step_instr(-1, 4'b0000, 1'b0, h);
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_pc", 32'(pc), 32'd1);

    noise_en = 1'b1;

    // add sets Z, jzero to 6 taken; then Z clear, falls through to 2.
    load(0, {5'b00000, 27'd0});
    load(1, {5'b10001, 23'd0, 4'd6});
    do_start();
    step_instr(-1, 4'b0100, 1'b1, h);
    step_instr(-1, 4'b0000, 1'b0, h);
    step_instr(-1, 4'b0000, 1'b0, h);
    chk("t2_taken_pc", 32'(pc), 32'd6);
    chk("t2_taken_halted", 32'(halted), 32'd1);
    do_start();
    step_instr(-1, 4'b0000, 1'b1, h);
    step_instr(-1, 4'b0000, 1'b0, h);
    step_instr(-1, 4'b0000, 1'b0, h);
    chk("t2_not_taken_pc", 32'(pc), 32'd2);

    // Jump vector table: ALU sets flags, instruction at 1 decides 9 vs 2.
    load(2, HALT_W);
    load(9, HALT_W);
    for (int i = 0; i < 19; i++) begin
      load(0, {5'b00010, 27'd0});
      load(1, {tbl[i].op, 23'd0, 4'd9});
      do_start();
      step_instr(-1, tbl[i].flags, 1'b1, h);
      step_instr(-1, 4'b0000, 1'b0, h);
      step_instr(-1, 4'b0000, 1'b0, h);
      chk("tbl_pc", 32'(pc), 32'(tbl[i].exp_pc));
      chk("tbl_halted", 32'(halted), 32'd1);
    end

    // Jump at 15 to 3, then NOP at 15 wrapping to 0.
    load(0, {5'b01100, 23'd0, 4'd15});
    load(15, {5'b01100, 23'd0, 4'd3});
    load(3, HALT_W);
    do_start();
    run_prog(5, h);
    chk("t3_jump_pc", 32'(pc), 32'd3);
    chk("t3_jump_halted", 32'(halted), 32'd1);
    load(15, {5'b10111, 27'd0});
    do_start();
    step_instr(-1, 4'b0000, 1'b0, h);
    step_instr(-1, 4'b0000, 1'b0, h);
    chk("t3_wrap_pc", 32'(pc), 32'd0);
    async_reset();

    // Reset in EXEC with ir_valid high, then rerun the same program.
    load(0, {5'b00011, 27'h123});
    load(1, HALT_W);
    do_start();
    tick();
    tick();
    chk("t5_exec_valid", 32'(ir_valid), 32'd1);
    async_reset();
    do_start();
    run_prog(5, h);
    chk("t5_rerun_pc", 32'(pc), 32'd1);
    chk("t5_rerun_halted", 32'(halted), 32'd1);

    // From HALT: rewrite mem[0] as halt and restart.
    load(0, HALT_W);
    do_start();
    tick();
    tick();
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_pc", 32'(pc), 32'd0);

    // From IDLE: write and start in the same cycle; first fetch sees new word.
    async_reset();
    start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = {5'b00100, 27'h77};
    tick();
    clear_noise();
    m_mem[0] = {5'b00100, 27'h77};
    tick();
    tick();
    chk("wr_start_ir", ir, {5'b00100, 27'h77});
    chk("wr_start_valid", 32'(ir_valid), 32'd1);
    async_reset();

    // Randomized programs against the model.
    for (int it = 0; it < 30; it++) begin
      for (int a = 0; a < DEPTH; a++) load(a, rand_instr());
      do_start();
      run_prog(40, h);
      if (!h) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
